// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   - DATA_W          : character width in bits
//   - PAR_*           : parity-mode encodings for the PARITY_BIT parameter
//   - uart_state_e    : FSM state encodings, also exported on the STATE debug port
//   - uart_rx_frame_t : payload presented to the byte consumer
//   - parity_error()  : parity check over a received character and its parity bit
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STATE_W  = 4;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4
  } uart_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par_err;
    logic              frm_err;
  } uart_rx_frame_t;

  // Even mode flags an odd total of ones; odd mode flags an even total.
  function automatic logic parity_error(input logic [DATA_W-1:0] data,
                                        input logic              par_bit,
                                        input logic              odd_mode);
    return (^{data, par_bit}) ^ odd_mode;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the CLK domain and
// flags falling edges on it.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset (synchronizer flops reset to 1)
//   i_rxd    : asynchronous serial input, idles high
//   o_rxd    : synchronized serial line
//   o_fall_c : combinational one-cycle flag on a high-to-low transition
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rxd,
  output logic o_rxd,
  output logic o_fall_c
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_fill;
  logic       r_armed;

  // Two-flop synchronizer, edge-detect copy, and an arm flag.
  // The flops come out of reset high, so a line that is already low would look
  // like a fresh fall; r_armed holds edge detection off until a real high level
  // has propagated through both synchronizer stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
      if ((r_fill == 2'd2) && r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rxd    = r_sync2;
  assign o_fall_c = r_armed & r_prev & ~r_sync2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first UART receiver with optional parity, sampled from a
// shared oversampling tick.
//   PARITY_BIT   : 0 none, 1 even, 2 odd
//   OVERSAMPLE   : UART_CLK_EN ticks per bit (even, >= 4)
//   CLK, RST     : clock, synchronous active-high reset
//   UART_CLK_EN  : oversample tick, one CLK wide
//   UART_RXD     : asynchronous serial input, idles high
//   DATA_OUT     : last received byte, held until the next DATA_VLD
//   DATA_VLD     : one-CLK pulse per completed frame
//   PARITY_ERROR : parity mismatch of the frame flagged by DATA_VLD, held
//   FRAME_ERROR  : stop bit sampled low for the frame flagged by DATA_VLD, held
//   BUSY         : high whenever the FSM is not idle
//   STATE        : current FSM state, for debug
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned PARITY_BIT = 0,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UART_CLK_EN,
  input  logic              UART_RXD,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VLD,
  output logic              PARITY_ERROR,
  output logic              FRAME_ERROR,
  output logic              BUSY,
  output logic [STATE_W-1:0] STATE
);

  localparam int unsigned     TICK_W     = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic            HAS_PARITY = (PARITY_BIT != PAR_NONE);
  localparam logic            ODD_PARITY = (PARITY_BIT == PAR_ODD);

  uart_state_e        r_state;
  uart_state_e        w_state_nxt;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [2:0]         r_bit_cnt;
  logic [DATA_W-1:0]  r_shreg;
  logic               r_par_err;
  uart_rx_frame_t     r_frame;
  logic               r_data_vld;
  logic               r_busy;

  logic w_rxd;
  logic w_fall;
  logic w_tick_mid;
  logic w_tick_end;
  logic w_shift;
  logic w_par_load;
  logic w_done;

  uart_rx_sync u_sync (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_rxd    (UART_RXD),
    .o_rxd    (w_rxd),
    .o_fall_c (w_fall)
  );

  // Sample points: the tick on which the counter sits at its terminal value.
  assign w_tick_mid = UART_CLK_EN && (r_tick_cnt == TICK_MID);
  assign w_tick_end = UART_CLK_EN && (r_tick_cnt == TICK_END);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_par_load  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A line that is high again at mid start bit was a glitch.
        if (w_tick_mid) begin
          w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick_end) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick_end) begin
          w_par_load  = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Returning to idle at mid stop bit leaves margin for back-to-back frames.
        if (w_tick_end) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shreg    <= '0;
      r_par_err  <= 1'b0;
      r_frame    <= '0;
      r_data_vld <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Cleared on every state entry and at the end of each bit period.
      if ((w_state_nxt != r_state) || (r_state == ST_IDLE) || w_tick_end) begin
        r_tick_cnt <= '0;
      end else if (UART_CLK_EN) begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end

      if (r_state != ST_DATA) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      // New bit enters at the MSB, so after eight shifts bit 0 is the first received.
      if (w_shift) begin
        r_shreg <= {w_rxd, r_shreg[DATA_W-1:1]};
      end

      if (w_par_load) begin
        r_par_err <= parity_error(r_shreg, w_rxd, ODD_PARITY);
      end

      r_data_vld <= w_done;
      if (w_done) begin
        r_frame <= '{data: r_shreg, par_err: r_par_err, frm_err: ~w_rxd};
      end

      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign DATA_OUT     = r_frame.data;
  assign PARITY_ERROR = r_frame.par_err;
  assign FRAME_ERROR  = r_frame.frm_err;
  assign DATA_VLD     = r_data_vld;
  assign BUSY         = r_busy;
  assign STATE        = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives three receivers (no parity, even, odd) with serial frames.
// Expected bytes/flags/arrival cycles are queued when a frame is sent; a monitor
// pops and compares whenever a DATA_VLD appears.
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct {
    int          id;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    longint      cyc;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            en;
  logic [2:0]      rxd;
  logic [2:0][7:0] dout;
  logic [2:0]      vld;
  logic [2:0]      pe;
  logic [2:0]      fe;
  logic [2:0]      busy;
  logic [2:0][3:0] st;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks;
  int     errors;
  int     div;
  int     tcnt;
  longint cyc;
  logic [7:0] lb [4];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx #(.PARITY_BIT(g), .OVERSAMPLE(OS)) u_dut (
      .CLK          (clk),
      .RST          (rst),
      .UART_CLK_EN  (en),
      .UART_RXD     (rxd[g]),
      .DATA_OUT     (dout[g]),
      .DATA_VLD     (vld[g]),
      .PARITY_ERROR (pe[g]),
      .FRAME_ERROR  (fe[g]),
      .BUSY         (busy[g]),
      .STATE        (st[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + longint'(1);

  // Oversample tick: one CLK in every `div`.
  initial begin
    tcnt = 0;
    en   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 1;
      en   = ((tcnt % div) == 0);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule: parity error from the count of ones over data and parity bit.
  function automatic logic model_pe(input int mode, input logic [7:0] d, input logic pbit);
    int ones;
    ones = $countones(d) + (pbit ? 1 : 0);
    if (mode == 1) return (ones % 2) == 1;
    if (mode == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic good_par(input int mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return (mode == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_bits(input int id, input logic b, input int nbits);
    rxd[id] = b;
    repeat (nbits * OS * div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic pbit,
                            input logic stop, input bit push);
    longint c;
    if (push) begin
      c = -1;
      if (div == 1) c = cyc + longint'(3 + OS / 2 + 9 * OS + ((id != 0) ? OS : 0));
      q.push_back('{id: id, d: d, pe: model_pe(id, d, pbit), fe: ~stop, cyc: c});
    end
    send_bits(id, 1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(id, d[i], 1);
    if (id != 0) send_bits(id, pbit, 1);
    send_bits(id, stop, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] === 1'b1) begin
        if (q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_vld: inst %0d data %0h with no frame pending (t=%0t)",
                   k, dout[k], $time);
        end else begin
          mon_e = q.pop_front();
          chk("vld_inst", longint'(k), longint'(mon_e.id));
          chk("data_out", longint'(dout[k]), longint'(mon_e.d));
          chk("parity_error", longint'(pe[k]), longint'(mon_e.pe));
          chk("frame_error", longint'(fe[k]), longint'(mon_e.fe));
          if (mon_e.cyc >= 0) chk("vld_latency", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       stop;
    int         id;
    int         gap;

    checks = 0;
    errors = 0;
    cyc    = 0;
    div    = 1;
    rst    = 1'b1;
    rxd    = 3'b111;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", longint'(dout[0]), 0);
    chk("rst_vld", longint'(vld[0]), 0);
    chk("rst_pe", longint'(pe[1]), 0);
    chk("rst_fe", longint'(fe[0]), 0);
    chk("rst_busy", longint'(busy[0]), 0);
    chk("rst_state", longint'(st[2]), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // No parity, 0x5A.
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    chk("busy_after_5a", longint'(busy[0]), 0);
    send_bits(0, 1'b1, 1);

    // Even and odd parity, correct and wrong parity bits.
    send_frame(1, 8'hA5, 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    send_frame(2, 8'hA5, 1'b0, 1'b1, 1'b1);
    send_frame(2, 8'hA5, 1'b1, 1'b1, 1'b1);
    send_bits(2, 1'b1, 1);

    // Framing error followed by a break; no further frames until a fresh fall.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_bits(0, 1'b0, 40);
    chk("break_pending", longint'(q.size()), 0);
    chk("break_state", longint'(st[0]), 0);
    send_bits(0, 1'b1, 1);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
    send_bits(0, 1'b1, 1);

    // Start-bit glitch of 4 ticks.
    rxd[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_state_start", longint'(st[0]), 1);
    chk("glitch_busy", longint'(busy[0]), 1);
    rxd[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_state_idle", longint'(st[0]), 0);
    chk("glitch_data_held", longint'(dout[0]), 8'h81);

    // Reset in the middle of data bit 4 of 0xFF.
    send_bits(0, 1'b0, 1);
    send_bits(0, 1'b1, 4);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_state", longint'(st[0]), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data_out", longint'(dout[0]), 0);
    chk("midrst_state", longint'(st[0]), 0);
    chk("midrst_busy", longint'(busy[0]), 0);
    chk("midrst_flags", longint'({pe[0], fe[0], vld[0]}), 0);
    rst = 1'b0;
    send_bits(0, 1'b1, 5);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
    send_bits(0, 1'b1, 1);

    // Back-to-back stream on every receiver, tick every other CLK.
    div = 2;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) send_frame(g, lb[i], good_par(g, lb[i]), 1'b1, 1'b1);
      send_bits(g, 1'b1, 1);
    end

    // Randomized frames, tick spacing and idle gaps.
    for (int n = 0; n < 24; n++) begin
      id   = int'($urandom_range(0, 2));
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      div  = int'($urandom_range(1, 3));
      gap  = int'($urandom_range(stop ? 0 : 1, 2));
      send_frame(id, d, ($urandom_range(0, 3) == 0) ? ~good_par(id, d) : good_par(id, d),
                 stop, 1'b1);
      if (gap > 0) send_bits(id, 1'b1, gap);
    end

    repeat (40) @(posedge clk);
    #1;
    chk("queue_drained", longint'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the existing `UART_TX`. It sits between the external serial input pin and the downstream byte consumer, for example the feature or command path. It samples an 8-bit, LSB-first frame with optional parity using a 16x oversampling enable from the shared baud generator. It presents each received byte with a one-cycle valid pulse, a parity status flag and a framing status flag.

## Interface
Parameters:
- `PARITY_BIT`, default 0. Parity mode, same encoding as `UART_TX`: 0 = none, 1 = even, 2 = odd.
- `OVERSAMPLE`, default 16. Number of `UART_CLK_EN` ticks per bit. Must be even and at least 4.

Ports:
- `CLK` in 1: system clock. One clock domain; all logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `UART_CLK_EN` in 1: oversample tick, one `CLK` wide, at `OVERSAMPLE` × baud rate.
- `UART_RXD` in 1: asynchronous serial input; the line idles high.
- `DATA_OUT` out 8: last received byte, held until the next `DATA_VLD`.
- `DATA_VLD` out 1: one-`CLK` pulse marking a completed frame.
- `PARITY_ERROR` out 1: parity mismatch for the frame flagged by `DATA_VLD`. Held. Always 0 when `PARITY_BIT`=0.
- `FRAME_ERROR` out 1: stop bit sampled low for the frame flagged by `DATA_VLD`. Held.
- `BUSY` out 1: high in every state other than IDLE.
- `STATE` out 4: current FSM state, for debug.

## Operation
- Input: `UART_RXD` passes through a 2-flop synchronizer (both flops reset to 1), then a registered copy gives falling-edge detection.
- Tick counter `tick_cnt` counts `UART_CLK_EN` pulses only. It is cleared on every state entry.
- Bit counter `bit_cnt` is 3 bits wide.
- FSM states, with `STATE` encoding:
  - IDLE = 0: wait for a falling edge on the synchronized line, then go to START.
  - START = 1: on tick `OVERSAMPLE/2-1` (mid start bit):
    - line still low → DATA, with `bit_cnt`=0.
    - line high → IDLE, treated as a glitch; no outputs change.
  - DATA = 2: on tick `OVERSAMPLE-1`:
    - shift the sample into `shreg[7]` and shift right, so the frame is LSB-first.
    - at `bit_cnt`=7 go to PARITY if `PARITY_BIT`≠0, otherwise go to STOP.
  - PARITY = 3: on tick `OVERSAMPLE-1`:
    - sample the parity bit.
    - compute the error: even mode = XOR of the 8 data bits and the parity bit ≠ 0; odd mode = that XOR = 0.
    - go to STOP.
  - STOP = 4: on tick `OVERSAMPLE-1`:
    - load `DATA_OUT` from `shreg`.
    - set `FRAME_ERROR` to the inverse of the sampled stop bit and load `PARITY_ERROR`.
    - pulse `DATA_VLD` and go to IDLE.
- Frames are always delivered: `DATA_VLD` pulses even when `FRAME_ERROR` or `PARITY_ERROR` is set.
- Break condition (line held low after the stop bit): no new frame starts until the line has returned high and a fresh falling edge is seen.
- There is no receive buffer. The consumer must take `DATA_OUT` before the next `DATA_VLD`.
- Undefined `STATE` encodings (5–15) → IDLE on the next `CLK`.
- Reset values: `DATA_OUT`=0, `DATA_VLD`=0, `PARITY_ERROR`=0, `FRAME_ERROR`=0, `BUSY`=0, `STATE`=0. Synchronizer flops reset to 1, counters to 0.

## Timing
- Synchronizer and edge detect add 3 `CLK` between a `UART_RXD` fall and the START entry.
- Each sample point is the rising `CLK` edge on which `UART_CLK_EN`=1 and `tick_cnt` reaches its terminal value.
- Line-fall to `DATA_VLD`:
  - no parity: 3 `CLK` + (`OVERSAMPLE/2` + 9·`OVERSAMPLE`) ticks, i.e. 152 ticks at 16x.
  - with parity: add `OVERSAMPLE` ticks.
- `DATA_VLD` is high for exactly one `CLK`. `DATA_OUT`, `PARITY_ERROR` and `FRAME_ERROR` change on the same edge that raises it.
- IDLE is re-entered at mid stop bit. This leaves half a bit of margin for back-to-back frames.
- `RST` asserted mid-frame: the next `CLK` returns every output to its reset value and the partial frame is discarded. The receiver then waits for a new falling edge. If the line is low when reset deasserts, nothing starts until the line rises and falls again.
- `UART_CLK_EN` held low freezes the FSM and counters. Edge detection in IDLE continues.

## Structure
- Shared package `uart_pkg`, also used by `UART_TX`:
  - state encodings IDLE/START/DATA/PARITY/STOP.
  - parity-mode constants `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2.
  - data width constant 8.
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector, with sync reset to 1. Everything else is flat in `uart_rx`.

## Test plan
- `PARITY_BIT`=0, `UART_CLK_EN` every `CLK`, send 0x5A with stop=1 → one `DATA_VLD`, `DATA_OUT`=0x5A, both error flags 0, `BUSY` low after the pulse.
- `PARITY_BIT`=1, send 0xA5 with parity bit 0 → `PARITY_ERROR`=0. Resend with parity bit 1 → `DATA_OUT`=0xA5, `PARITY_ERROR`=1. Repeat with `PARITY_BIT`=2 → flags inverted.
- Send 0x3C with stop bit 0, then hold the line low for 40 bit times → exactly one `DATA_VLD` with `FRAME_ERROR`=1 and no further frames. Then raise the line and send 0x81 → `DATA_OUT`=0x81, `FRAME_ERROR`=0.
- Drive the line low for 4 ticks, then high → state goes START→IDLE, no `DATA_VLD`, `DATA_OUT` unchanged.
- Assert `RST` during DATA bit 4 of 0xFF → all outputs 0 on the next `CLK`. Then send 0x12 → `DATA_OUT`=0x12.
- Loopback from `UART_TX` (same `PARITY_BIT`, RX tick = 16× TX tick) over 0x00, 0xFF, 0x5A and 0xA5 sent back-to-back → four `DATA_VLD` pulses in order, with matching bytes and no errors.
